// File: rtl/atm_session_pkg.sv
// Shared types and constants for the ATM session controller.
// Op codes, status/state enums and the latched request record.
package atm_session_pkg;

    localparam logic [2:0] OP_BALANCE     = 3'd3;
    localparam logic [2:0] OP_WITHDRAW    = 3'd4;
    localparam logic [2:0] OP_DEPOSIT     = 3'd5;
    localparam logic [2:0] OP_CHANGE_PIN  = 3'd6;
    localparam logic [2:0] ATM_IDLE_STATE = 3'd7;

    localparam int FAIL_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_FAIL   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_BAD_OP = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_RECOVER,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  acc;
        logic [15:0] pin;
        logic [15:0] new_pin;
        logic [31:0] amount;
        logic        language;
    } req_t;

    function automatic logic op_supported(
        input logic [2:0] op
    );
        return (op >= OP_BALANCE) &&
               (op <= OP_CHANGE_PIN);
    endfunction

endpackage

// File: rtl/atm_session_ctrl_lock_table.sv
// Per-account fail counters and lock bits.
// Ports: lookup (acc -> locked, comb), update (valid/acc/pass), unlock.
module atm_lock_table
    import atm_session_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 16,
    parameter int MAX_FAILS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] lookup_acc,
    output logic       lookup_locked,
    input  logic       upd_valid,
    input  logic [3:0] upd_acc,
    input  logic       upd_pass,
    input  logic       unlock_valid,
    input  logic [3:0] unlock_acc
);

    localparam logic [FAIL_CNT_W-1:0] MAX_CNT =
        FAIL_CNT_W'(MAX_FAILS);
    localparam logic [FAIL_CNT_W-1:0] LOCK_AT =
        FAIL_CNT_W'(MAX_FAILS - 1);

    logic [FAIL_CNT_W-1:0]   cnt_q [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] lock_q;

    assign lookup_locked = lock_q[lookup_acc];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                cnt_q[i] <= '0;
            end
            lock_q <= '0;
        end else begin
            if (upd_valid) begin
                if (upd_pass) begin
                    cnt_q[upd_acc] <= '0;
                end else if (cnt_q[upd_acc] >= LOCK_AT) begin
                    cnt_q[upd_acc]  <= MAX_CNT;
                    lock_q[upd_acc] <= 1'b1;
                end else begin
                    cnt_q[upd_acc] <= cnt_q[upd_acc] + 1'b1;
                end
            end
            // Placed last so an unlock overrides a same-edge update.
            if (unlock_valid) begin
                cnt_q[unlock_acc]  <= '0;
                lock_q[unlock_acc] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// Initiator-side session controller for the ATM core with lockout.
// Ports: req_* in (valid/ready), resp_* out (valid/ready), unlock_*,
// atm_* drive/capture toward the ATM core (atm_enable = core run).
module atm_session_ctrl
    import atm_session_pkg::*;
#(
    parameter int HOLD_CYCLES  = 4,
    parameter int NUM_ACCOUNTS = 16,
    parameter int MAX_FAILS    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_acc_num,
    input  logic [15:0] req_pin,
    input  logic [15:0] req_new_pin,
    input  logic [31:0] req_amount,
    input  logic        req_language,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [1:0]  resp_status,
    output logic [31:0] resp_balance,
    input  logic        unlock_valid,
    input  logic [3:0]  unlock_acc,
    output logic        atm_enable,
    output logic [2:0]  atm_operation,
    output logic [3:0]  atm_acc_num,
    output logic [15:0] atm_pin,
    output logic [15:0] atm_new_pin,
    output logic [31:0] atm_amount,
    output logic        atm_language,
    input  logic [31:0] atm_balance,
    input  logic        atm_success,
    input  logic [2:0]  atm_state
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    state_e      state;
    status_e     st_q;
    req_t        req_q;
    logic [CW-1:0] hold_q;
    logic        acc_locked;

    // Core state is not needed: the hold window alone frames a txn.
    logic unused_state;
    assign unused_state = ^atm_state;

    assign resp_status = st_q;

    atm_lock_table #(
        .NUM_ACCOUNTS(NUM_ACCOUNTS),
        .MAX_FAILS   (MAX_FAILS)
    ) u_lock (
        .clk          (clk),
        .rst          (rst),
        .lookup_acc   (req_q.acc),
        .lookup_locked(acc_locked),
        .upd_valid    (state == S_RECOVER),
        .upd_acc      (req_q.acc),
        .upd_pass     (st_q == ST_OK),
        .unlock_valid (unlock_valid),
        .unlock_acc   (unlock_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            st_q          <= ST_OK;
            req_q         <= '0;
            hold_q        <= '0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_balance  <= '0;
            atm_enable    <= 1'b0;
            atm_operation <= '0;
            atm_acc_num   <= '0;
            atm_pin       <= '0;
            atm_new_pin   <= '0;
            atm_amount    <= '0;
            atm_language  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_q.op       <= req_op;
                        req_q.acc      <= req_acc_num;
                        req_q.pin      <= req_pin;
                        req_q.new_pin  <= req_new_pin;
                        req_q.amount   <= req_amount;
                        req_q.language <= req_language;
                        req_ready      <= 1'b0;
                        state          <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!op_supported(req_q.op)) begin
                        st_q         <= ST_BAD_OP;
                        resp_balance <= '0;
                        state        <= S_RESP;
                    end else if (acc_locked) begin
                        st_q         <= ST_LOCKED;
                        resp_balance <= '0;
                        state        <= S_RESP;
                    end else begin
                        atm_enable    <= 1'b1;
                        atm_operation <= req_q.op;
                        atm_acc_num   <= req_q.acc;
                        atm_pin       <= req_q.pin;
                        atm_new_pin   <= req_q.new_pin;
                        atm_amount    <= req_q.amount;
                        atm_language  <= req_q.language;
                        hold_q        <= '0;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (hold_q == LAST) begin
                        resp_balance  <= atm_balance;
                        st_q          <= atm_success ?
                                         ST_OK : ST_FAIL;
                        atm_enable    <= 1'b0;
                        atm_operation <= '0;
                        atm_acc_num   <= '0;
                        atm_pin       <= '0;
                        atm_new_pin   <= '0;
                        atm_amount    <= '0;
                        atm_language  <= 1'b0;
                        state         <= S_RECOVER;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_RECOVER: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    resp_valid <= 1'b1;
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Initiator side of the ATM core transaction interface. It drives the operation, account, PIN, amount and language inputs, then captures balance and success.
- Accepts customer requests over a valid/ready handshake and holds each request on the ATM inputs for a fixed number of cycles.
- Returns ATM core to idle between transactions and returns a response record over a second handshake.
- Adds per-account consecutive-failure lockout, so locked accounts never reach the ATM core.

Parameters:
- HOLD_CYCLES, 4, cycles the ATM inputs are held with atm_enable=1 per transaction.
- NUM_ACCOUNTS, 16, lock-table depth, indexed by acc_num.
- MAX_FAILS, 3, consecutive failures that lock an account.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  controller can accept a request.
- req_op  in  3  operation: 3 balance, 4 withdraw, 5 deposit, 6 change PIN.
- req_acc_num  in  4  account number.
- req_pin  in  16  PIN.
- req_new_pin  in  16  new PIN (op 6).
- req_amount  in  32  amount (ops 4/5).
- req_language  in  1  language select.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_status  out  2  0 OK, 1 FAIL, 2 LOCKED, 3 BAD_OP.
- resp_balance  out  32  captured atm_balance; 0 unless status OK or FAIL.
- unlock_valid  in  1  clear lock and fail count for unlock_acc.
- unlock_acc  in  4  account to unlock.
- atm_enable  out  1  drives ATM core rst input (1 = run, 0 = force ATM idle).
- atm_operation  out  3  to ATM core.
- atm_acc_num  out  4  to ATM core.
- atm_pin  out  16  to ATM core.
- atm_new_pin  out  16  to ATM core.
- atm_amount  out  32  to ATM core.
- atm_language  out  1  to ATM core.
- atm_balance  in  32  from ATM core.
- atm_success  in  1  from ATM core.
- atm_state  in  3  from ATM core; 7 = idle.

Behaviour:
- Reset values (rst=1 at a clock edge, any state):
  - FSM goes to IDLE; lock table cleared.
  - req_ready=0 during the reset cycle, then 1.
  - resp_valid=0, resp_status=0, resp_balance=0, atm_enable=0.
  - All atm_* data outputs 0.
  - Reset mid-transaction abandons it; no response is produced.
- FSM states: IDLE, CHECK, ISSUE, RECOVER, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch all req_* fields and go to CHECK.
- CHECK (1 cycle, atm_enable=0):
  - op not in 3..6: status BAD_OP.
  - Else if the account is locked: status LOCKED.
  - Both cases go to RESP with resp_balance=0.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive atm_* from the latched fields with atm_enable=1 for exactly HOLD_CYCLES cycles.
  - On the last ISSUE edge, capture atm_balance and atm_success. Success gives OK, else FAIL.
  - Go to RECOVER.
- RECOVER (1 cycle):
  - atm_enable=0, atm_* data zeroed.
  - Lock-table update is applied at this edge.
- RESP:
  - resp_valid=1 with stable status/balance until resp_valid&&resp_ready, then return to IDLE.
  - req_ready=0 throughout RESP.
- Latency from accept edge to resp_valid high:
  - Issued transactions: HOLD_CYCLES+3 cycles.
  - BAD_OP/LOCKED: 2 cycles.
- Back-to-back requests: the next accept is possible the cycle after the response handshake. No pipelining.
- Lock table:
  - Per account: 2-bit fail counter plus lock bit.
  - OK clears the counter.
  - FAIL increments the counter; reaching MAX_FAILS sets lock and saturates the counter.
  - BAD_OP and LOCKED do not change the counter.
- Unlock:
  - unlock_valid is accepted in any state; it clears the counter and lock for unlock_acc at that edge.
  - If an unlock and a RECOVER-edge update hit the same account in the same cycle, unlock wins.
  - A CHECK in the same cycle as an unlock sees the pre-unlock value.
- An atm_state value other than 7 during IDLE is ignored.

Decomposition:
- Package atm_session_pkg:
  - op code constants OP_BALANCE=3, OP_WITHDRAW=4, OP_DEPOSIT=5, OP_CHANGE_PIN=6.
  - ATM_IDLE_STATE=7.
  - status enum (OK, FAIL, LOCKED, BAD_OP).
  - FSM state enum.
  - packed request struct.
- Sub-module atm_lock_table holds the counters and lock bits. Its interface:
  - lookup port: acc → locked, combinational.
  - update port: valid, acc, pass/fail.
  - unlock port.

Test Plan:
- acc 1, pin 1234, op 3 → atm_enable high exactly 4 cycles; resp_valid 7 cycles after accept; status OK; resp_balance = DB balance of acc 1.
- acc 3, op 5, amount 1000 → OK, resp_balance = B3+1000. Then op 4, amount B3+1100 → FAIL.
- acc 2, op 3, wrong pin 9999, three times → FAIL×3. Fourth request → LOCKED, 2-cycle latency, atm_enable stays 0. unlock_valid acc 2, then correct pin 2345 → OK.
- op 1 on acc 4 → BAD_OP, atm_enable never asserted, lock counter unchanged.
- resp_ready held 0 for 10 cycles → resp_valid, status and balance stable; req_ready=0 throughout.
- rst=1 on the 2nd ISSUE cycle → next cycle atm_enable=0, all outputs at reset values, lock table cleared, no response emitted.
